// File: rtl/sum_block_avg_if.sv
// Handshake bundle for sum_block_avg: sample stream in, block statistics out.
// out_min/out_max exist only when SUM_BLOCK_MINMAX_EN is defined.
interface sum_block_avg_if #(
    parameter int BLOCK_LOG2 = 2,
    parameter int DW         = 8
);
    logic                     in_valid;
    logic [DW-1:0]            in_data;
    logic                     in_ready;
    logic                     out_valid;
    logic                     out_ready;
    logic [DW+BLOCK_LOG2-1:0] out_sum;
    logic [DW-1:0]            out_avg;
    logic [7:0]               out_seq;
`ifdef SUM_BLOCK_MINMAX_EN
    logic [DW-1:0]            out_min;
    logic [DW-1:0]            out_max;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_sum, out_avg, out_seq, out_min, out_max
    );
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_sum, out_avg, out_seq, out_min, out_max
    );
`else
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_sum, out_avg, out_seq
    );
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_sum, out_avg, out_seq
    );
`endif
endinterface

// File: rtl/sum_block_avg.sv
// Accumulates 2^BLOCK_LOG2 unsigned samples per block and holds total, average and sequence
// number until taken. Optional per-block min/max enabled by SUM_BLOCK_MINMAX_EN.
module sum_block_avg #(
    parameter int BLOCK_LOG2 = 2,
    parameter int DW         = 8
) (
    input  logic            clk,
    input  logic            rst,
    sum_block_avg_if.slave  bus
);
    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t                   state;
    state_t                   state_nxt;
    logic [BLOCK_LOG2-1:0]    cnt;
    logic [DW+BLOCK_LOG2-1:0] acc;
    logic [DW+BLOCK_LOG2-1:0] total;
    logic [DW+BLOCK_LOG2-1:0] sum_q;
    logic [DW-1:0]            avg_q;
    logic [7:0]               seq_q;
    logic                     in_ready_c;
    logic                     out_valid_c;
    logic                     accept;
    logic                     last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ACCUM;
        end else begin
            state <= state_nxt;
        end
    end

    // Handshake outputs decode from state alone; no input-to-output combinational path.
    always_comb begin
        state_nxt   = state;
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        case (state)
            ACCUM: begin
                in_ready_c = 1'b1;
                if (bus.in_valid && (cnt == '1)) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                out_valid_c = 1'b1;
                if (bus.out_ready) begin
                    state_nxt = ACCUM;
                end
            end
            default: state_nxt = ACCUM;
        endcase
    end

    assign accept = in_ready_c & bus.in_valid;
    assign last   = accept & (cnt == '1);
    assign total  = acc + {{BLOCK_LOG2{1'b0}}, bus.in_data};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc   <= '0;
            cnt   <= '0;
            sum_q <= '0;
            avg_q <= '0;
            seq_q <= '0;
        end else begin
            if (accept) begin
                cnt <= cnt + 1'b1;
                if (last) begin
                    acc   <= '0;
                    sum_q <= total;
                    avg_q <= total[DW+BLOCK_LOG2-1:BLOCK_LOG2];
                end else begin
                    acc <= total;
                end
            end
            if (out_valid_c && bus.out_ready) begin
                seq_q <= seq_q + 8'd1;
            end
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.out_sum   = sum_q;
    assign bus.out_avg   = avg_q;
    assign bus.out_seq   = seq_q;

`ifdef SUM_BLOCK_MINMAX_EN
    logic [DW-1:0] run_min;
    logic [DW-1:0] run_max;
    logic [DW-1:0] blk_min;
    logic [DW-1:0] blk_max;
    logic [DW-1:0] min_q;
    logic [DW-1:0] max_q;

    // The first sample of a block (cnt==0) restarts the running extremes.
    always_comb begin
        blk_min = bus.in_data;
        blk_max = bus.in_data;
        if (cnt != '0) begin
            if (run_min < bus.in_data) blk_min = run_min;
            if (run_max > bus.in_data) blk_max = run_max;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_min <= '0;
            run_max <= '0;
            min_q   <= '0;
            max_q   <= '0;
        end else if (accept) begin
            run_min <= blk_min;
            run_max <= blk_max;
            if (last) begin
                min_q <= blk_min;
                max_q <= blk_max;
            end
        end
    end

    assign bus.out_min = min_q;
    assign bus.out_max = max_q;
`endif
endmodule
